// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ requesters.
// Each owner gets up to BURST consecutive writes before ownership rotates.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wr_enable,
  output logic [WIDTH-1:0]          fifo_data_in,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner_q;
  logic [CW-1:0] cnt;

  logic [PW-1:0] pick;
  logic [PW-1:0] owner_inc;
  logic [CW:0]   cnt_inc;
  logic          last;
  logic          w;

  // Round-robin search: first set req bit starting at ptr, wrapping below NREQ
  always_comb begin
    logic [PW:0] idx;
    logic        found;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (PW+1)'(ptr) + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (!found && req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  // Write qualifier, burst bookkeeping and rotation target
  always_comb begin
    w         = (state == S_OWN) && req[owner_q] && !fifo_full && !reset;
    cnt_inc   = {1'b0, cnt} + (CW+1)'(1);
    last      = (cnt_inc == (CW+1)'(BURST));
    owner_inc = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
  end

  // Ownership state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      owner_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner_q <= pick;
            cnt     <= '0;
            state   <= S_OWN;
          end
        end
        S_OWN: begin
          if (!req[owner_q]) begin
            state <= S_IDLE;
            ptr   <= owner_inc;
          end else if (w && last) begin
            state <= S_IDLE;
            ptr   <= owner_inc;
          end else if (w) begin
            cnt <= cnt_inc[CW-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write-side outputs, forced quiet while reset is asserted
  always_comb begin
    gnt            = '0;
    fifo_wr_enable = 1'b0;
    fifo_data_in   = '0;
    if (w) begin
      gnt[owner_q]   = 1'b1;
      fifo_wr_enable = 1'b1;
      fifo_data_in   = req_data[int'(owner_q)*WIDTH +: WIDTH];
    end
    busy  = (state == S_OWN) && !reset;
    owner = reset ? '0 : owner_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: requester queues feed req/req_data,
// a scoreboard queue holds the words the FIFO must receive in order.
module tb_fifo_wr_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr_enable;
  logic [WIDTH-1:0]      fifo_data_in;
  logic [1:0]            owner;
  logic                  busy;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_full      (fifo_full),
    .fifo_wr_enable (fifo_wr_enable),
    .fifo_data_in   (fifo_data_in),
    .owner          (owner),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] src_q [NREQ][$];
  logic [7:0] exp_q [$];

  logic [3:0] s_gnt;
  logic       s_wen;
  logic [7:0] s_data;
  logic [1:0] s_owner;
  logic       s_busy;

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (src_q[i].size() != 0);
      req_data[i*WIDTH +: WIDTH] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // One clock: sample mid-cycle, score any write, then advance past the edge
  task automatic step();
    logic [7:0] e;
    #3;
    s_gnt   = gnt;
    s_wen   = fifo_wr_enable;
    s_data  = fifo_data_in;
    s_owner = owner;
    s_busy  = busy;
    if (s_wen) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: unexpected write data=%h", s_data);
      end else begin
        e = exp_q.pop_front();
        if (s_data !== e) begin
          n_err++;
          $display("FAIL scoreboard: data=%h expected=%h", s_data, e);
        end
      end
      if (fifo_full) begin
        n_vec++;
        n_err++;
        $display("FAIL write_while_full: wr_enable=1 expected=0");
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (s_gnt[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive_req();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || src_pending()) && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0 || src_pending()) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words still expected, expected 0", exp_q.size());
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      drive_req();
    end
    repeat (3) step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].push_back(8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
    end
    drive_req();
    step();
    n_vec++;
    if ({s_gnt, s_wen, s_data, s_owner, s_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_cycle_outputs: gnt=%b wen=%b data=%h owner=%0d busy=%b expected all 0",
               s_gnt, s_wen, s_data, s_owner, s_busy);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if ({s_gnt, s_wen, s_data, s_owner, s_busy} !== '0) begin
      n_err++;
      $display("FAIL first_idle_outputs: gnt=%b wen=%b data=%h owner=%0d busy=%b expected all 0",
               s_gnt, s_wen, s_data, s_owner, s_busy);
    end
    step();
    n_vec++;
    if (s_owner !== 2'd0 || s_gnt !== 4'b0001 || s_data !== 8'h10) begin
      n_err++;
      $display("FAIL first_grant: owner=%0d gnt=%b data=%h expected 0 0001 10", s_owner, s_gnt, s_data);
    end
    drain(40);
  endtask

  task automatic test_single_stream();
    logic [7:0] pat;
    pat = 8'b10110110;
    for (int j = 0; j < 5; j++) begin
      src_q[2].push_back(8'(8'hA0 + j));
      exp_q.push_back(8'(8'hA0 + j));
    end
    drive_req();
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++;
      if (s_wen !== pat[k] || (s_wen && s_owner !== 2'd2)) begin
        n_err++;
        $display("FAIL single_pattern[%0d]: wen=%b owner=%0d expected wen=%b owner=2", k, s_wen, s_owner, pat[k]);
      end
      if (k == 3 || k == 6) begin
        n_vec++;
        if (dut.ptr !== 2'd3) begin
          n_err++;
          $display("FAIL single_ptr[%0d]: ptr=%0d expected 3", k, dut.ptr);
        end
      end
    end
    drain(10);
  endtask

  task automatic test_all_four();
    int wi;
    int ow;
    int ec;
    pulse_reset();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 4; j++) src_q[i].push_back(8'(8'h40 + i*16 + j));
    for (int n = 0; n < 16; n++)
      exp_q.push_back(8'(8'h40 + ((n/2)%4)*16 + (n/8)*2 + n%2));
    drive_req();
    wi = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (s_wen) begin
        ow = (wi/2) % 4;
        ec = 3*(wi/2) + 1 + (wi%2);
        n_vec++;
        if (s_owner !== 2'(ow) || c != ec) begin
          n_err++;
          $display("FAIL rr_order[%0d]: owner=%0d cycle=%0d expected owner=%0d cycle=%0d", wi, s_owner, c, ow, ec);
        end
        wi++;
      end
    end
    n_vec++;
    if (wi != 16) begin
      n_err++;
      $display("FAIL rr_count: writes=%0d expected 16", wi);
    end
    drain(10);
  endtask

  task automatic test_full_stall();
    pulse_reset();
    src_q[1].push_back(8'h51);
    src_q[1].push_back(8'h52);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    drive_req();
    step();
    step();
    n_vec++;
    if (s_wen !== 1'b1 || s_owner !== 2'd1) begin
      n_err++;
      $display("FAIL stall_first_write: wen=%b owner=%0d expected 1 1", s_wen, s_owner);
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (s_gnt !== 4'b0000 || s_wen !== 1'b0 || s_owner !== 2'd1 || dut.cnt !== 2'd1) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: gnt=%b wen=%b owner=%0d cnt=%0d expected 0000 0 1 1",
                 k, s_gnt, s_wen, s_owner, dut.cnt);
      end
    end
    fifo_full = 1'b0;
    step();
    n_vec++;
    if (s_wen !== 1'b1 || s_gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL stall_resume: wen=%b gnt=%b expected 1 0010", s_wen, s_gnt);
    end
    step();
    n_vec++;
    if (s_wen !== 1'b0 || s_busy !== 1'b0 || dut.ptr !== 2'd2) begin
      n_err++;
      $display("FAIL stall_release: wen=%b busy=%b ptr=%0d expected 0 0 2", s_wen, s_busy, dut.ptr);
    end
    drain(10);
  endtask

  task automatic test_drop_wrap();
    src_q[3].push_back(8'h63);
    exp_q.push_back(8'h63);
    exp_q.push_back(8'h60);
    drive_req();
    step();
    step();
    n_vec++;
    if (s_wen !== 1'b1 || s_owner !== 2'd3) begin
      n_err++;
      $display("FAIL drop_first_write: wen=%b owner=%0d expected 1 3", s_wen, s_owner);
    end
    src_q[0].push_back(8'h60);
    drive_req();
    step();
    n_vec++;
    if (s_wen !== 1'b0 || s_busy !== 1'b1 || s_owner !== 2'd3) begin
      n_err++;
      $display("FAIL drop_release_cycle: wen=%b busy=%b owner=%0d expected 0 1 3", s_wen, s_busy, s_owner);
    end
    step();
    n_vec++;
    if (s_busy !== 1'b0 || dut.ptr !== 2'd0) begin
      n_err++;
      $display("FAIL drop_wrap: busy=%b ptr=%0d expected 0 0", s_busy, dut.ptr);
    end
    step();
    n_vec++;
    if (s_owner !== 2'd0 || s_gnt !== 4'b0001 || s_data !== 8'h60) begin
      n_err++;
      $display("FAIL drop_next_owner: owner=%0d gnt=%b data=%h expected 0 0001 60", s_owner, s_gnt, s_data);
    end
    drain(10);
  endtask

  task automatic test_reset_mid_burst();
    src_q[2].push_back(8'h72);
    src_q[2].push_back(8'h73);
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h71);
    exp_q.push_back(8'h73);
    drive_req();
    step();
    step();
    n_vec++;
    if (s_owner !== 2'd2 || dut.owner_q !== 2'd2 || dut.cnt !== 2'd1) begin
      n_err++;
      $display("FAIL midreset_setup: owner=%0d cnt=%0d expected 2 1", dut.owner_q, dut.cnt);
    end
    reset = 1'b1;
    src_q[1].push_back(8'h71);
    drive_req();
    step();
    n_vec++;
    if ({s_gnt, s_wen, s_data, s_owner, s_busy} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: gnt=%b wen=%b data=%h owner=%0d busy=%b expected all 0",
               s_gnt, s_wen, s_data, s_owner, s_busy);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (s_busy !== 1'b0 || s_wen !== 1'b0 || dut.ptr !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_idle: busy=%b wen=%b ptr=%0d expected 0 0 0", s_busy, s_wen, dut.ptr);
    end
    step();
    n_vec++;
    if (s_owner !== 2'd1 || s_gnt !== 4'b0010 || s_data !== 8'h71) begin
      n_err++;
      $display("FAIL midreset_next_owner: owner=%0d gnt=%b data=%h expected 1 0010 71", s_owner, s_gnt, s_data);
    end
    drain(20);
  endtask

  initial begin
    reset     = 1'b1;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;
    test_reset();
    test_single_stream();
    test_all_four();
    test_full_stall();
    test_drop_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one synchronous FIFO among NREQ requesters. It sits directly in front of the FIFO's write_enable/data_in pins and watches the FIFO's full flag. A bounded burst counter gives each owner up to BURST consecutive writes before ownership rotates. All state is in the single clk domain.

## Interface
Parameters:
- WIDTH, 8: data word width; must match the FIFO WIDTH.
- NREQ, 4: number of requesters, 2..16.
- BURST, 2: maximum writes per ownership, 1..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester. Bit i holds high until gnt[i] is seen for each word.
- req_data  in  NREQ*WIDTH  requester i's word on bits [i*WIDTH +: WIDTH]; stable while req[i] is high.
- gnt  out  NREQ  one-hot; gnt[i]=1 means requester i's word is written at this clock edge.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_enable  out  1  FIFO write enable.
- fifo_data_in  out  WIDTH  FIFO write data.
- owner  out  $clog2(NREQ)  current owner index; meaningful only when busy=1.
- busy  out  1  high in the OWN state.

## Operation
- State machine with two states: IDLE and OWN.
- Registers:
  - state
  - ptr: round-robin start index
  - owner
  - cnt: burst count, 0..BURST
- IDLE:
  - No grants are issued.
  - If any req bit is set, owner <= the first set bit searching ptr, ptr+1, … modulo NREQ. Then cnt <= 0 and state <= OWN.
  - If no req bit is set, stay in IDLE.
- OWN, one write condition per cycle: w = req[owner] & ~fifo_full.
  - When w=1: gnt[owner]=1, fifo_wr_enable=1, fifo_data_in = req_data slice of owner.
  - When w=0: gnt=0, fifo_wr_enable=0.
- OWN transitions, in priority order:
  - If req[owner]=0: state <= IDLE and ptr <= (owner+1) mod NREQ. This releases ownership immediately.
  - Else if w=1 and cnt+1 == BURST: state <= IDLE and ptr <= (owner+1) mod NREQ.
  - Else if w=1: cnt <= cnt+1 and stay in OWN.
  - Else (stalled on fifo_full): hold owner and cnt, stay in OWN. There is no timeout.
- Combinational outputs are gated by reset: while reset=1, gnt, fifo_wr_enable and busy are 0.
- fifo_data_in is 0 whenever fifo_wr_enable=0.
- Words from one requester reach the FIFO in request order. Words from different requesters interleave only at ownership boundaries.
- The arbiter never asserts fifo_wr_enable while fifo_full=1.

## Timing
- Reset (synchronous): state=IDLE, ptr=0, owner=0, cnt=0. In the reset cycle and the following IDLE cycle, every output is 0.
- Arbitration latency: one IDLE cycle between req rising (or ownership release) and the first gnt.
- Throughput:
  - A single continuous requester gets BURST writes per BURST+1 cycles.
  - With NREQ requesters all active, each gets BURST words per round of NREQ*(BURST+1) cycles, absent full stalls.
- gnt, fifo_wr_enable and fifo_data_in are combinational from registered state plus req/fifo_full/req_data in the same cycle. The FIFO captures at the same edge at which the arbiter updates cnt.
- fifo_full rising mid-burst: the write is suppressed in that same cycle and resumes in the first cycle fifo_full=0. cnt is preserved across the stall.
- If reset is asserted during OWN, the next edge enters IDLE with ptr=0. The partially used burst is discarded and no word is lost, because an ungranted requester still holds req.
- ptr wraps from NREQ-1 to 0.
- Non-power-of-two NREQ: the search never selects an index ≥ NREQ.

## Test plan
All scenarios use NREQ=4, BURST=2, WIDTH=8.
- Reset, then req=4'b1111: every output is 0 in the reset cycle and the first IDLE cycle. Next cycle owner=0, gnt=4'b0001 and fifo_data_in = requester 0's word.
- Only req[2] high, streaming 0xA0..0xA4:
  - Cycle pattern is IDLE, W, W, IDLE, W, W, IDLE, W.
  - The FIFO receives 0xA0..0xA4 in order.
  - ptr=3 after each burst.
- All four requesters streaming continuously: owner sequence 0,1,2,3,0, two gnts per ownership, one IDLE cycle between ownerships.
- Owner 1 after one write, fifo_full=1 for 3 cycles:
  - gnt=0 and fifo_wr_enable=0 for those 3 cycles; owner stays 1 and cnt stays 1.
  - When full drops: exactly one more write, then IDLE with ptr=2.
- Owner 3 drops req after one write: next state is IDLE and ptr wraps to 0. If req[0] is high, owner 0 is selected.
- Reset pulsed mid-burst with owner 2 and cnt=1:
  - Outputs are 0 during the reset cycle.
  - After reset: IDLE with ptr=0.
  - With req=4'b0110, owner 1 is selected next.
